// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: request/response packet field
// positions and the sink controller state encoding.
`timescale 1ns/1ps
package bridge_pkg;

  localparam int RW_BIT        = 65;
  localparam int VALID_BIT     = 64;
  localparam int ADDR_MSB      = 63;
  localparam int ADDR_LSB      = 32;
  localparam int DATA_MSB      = 31;
  localparam int DATA_LSB      = 0;
  localparam int RSP_VALID_BIT = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4,
    DRAIN  = 3'd5,
    SLEEP  = 3'd6
  } state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts APB ACCESS cycles without PREADY; tc flags the last permitted cycle.
`timescale 1ns/1ps
module apb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q, cnt_d;

  assign tc = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sink_apb_controller.sv
// Sink-side bridge stage: pops request packets, runs them as APB3 transfers,
// pushes read responses and owns the sink sleep handshake.
`timescale 1ns/1ps
module sink_apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int packet_width = 66,
  parameter int TIMEOUT      = 16
) (
  input  logic                    i_clk_sink,
  input  logic                    i_rstn_sink,
  input  logic [packet_width-1:0] i_req_packet,
  input  logic                    req_fifo_empty,
  output logic                    req_fifo_rd_en,
  input  logic                    rsp_fifo_full,
  output logic                    rsp_fifo_wr_en,
  output logic [DATA_WIDTH:0]     o_rsp_packet,
  input  logic                    i_sink_sleep_req,
  output logic                    o_sink_sleep_ack,
  output logic                    sink_sleep_status,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  output logic                    o_err
);

  state_e                state_q, state_d, ret_state;
  logic                  drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rsp_wr_en_q, rsp_wr_en_d;
  logic [DATA_WIDTH:0]   rsp_pkt_q, rsp_pkt_d;
  logic                  err_q, err_d;
  logic                  cnt_clr, cnt_en, cnt_tc;

  apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (i_clk_sink),
    .rst_n (i_rstn_sink),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign cnt_en = (state_q == ACCESS) && !PREADY;

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    paddr_d        = paddr_q;
    pwdata_d       = pwdata_q;
    pwrite_d       = pwrite_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    rd_data_d      = rd_data_q;
    rsp_wr_en_d    = 1'b0;
    rsp_pkt_d      = rsp_pkt_q;
    err_d          = 1'b0;
    cnt_clr        = 1'b0;
    req_fifo_rd_en = 1'b0;
    // Transfers started while draining come back to DRAIN so it can finish the queue.
    ret_state      = drain_q ? DRAIN : IDLE;

    case (state_q)
      IDLE: begin
        if (i_sink_sleep_req) begin
          state_d = DRAIN;
          drain_d = 1'b1;
        end else if (!req_fifo_empty) begin
          req_fifo_rd_en = 1'b1;
          state_d        = FETCH;
        end
      end
      DRAIN: begin
        if (!i_sink_sleep_req) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end else if (!req_fifo_empty) begin
          req_fifo_rd_en = 1'b1;
          state_d        = FETCH;
        end else begin
          state_d = SLEEP;
        end
      end
      FETCH: begin
        if (!i_req_packet[VALID_BIT]) begin
          state_d = ret_state;
        end else begin
          paddr_d   = i_req_packet[ADDR_MSB:ADDR_LSB];
          pwdata_d  = i_req_packet[DATA_MSB:DATA_LSB];
          pwrite_d  = i_req_packet[RW_BIT];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the terminal cycle is not aborted.
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rd_data_d = PSLVERR ? '0 : PRDATA;
          err_d     = PSLVERR;
          state_d   = pwrite_q ? ret_state : RESP;
        end else if (cnt_tc) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rd_data_d = '0;
          err_d     = 1'b1;
          state_d   = pwrite_q ? ret_state : RESP;
        end
      end
      RESP: begin
        if (!rsp_fifo_full) begin
          rsp_wr_en_d                      = 1'b1;
          rsp_pkt_d[RSP_VALID_BIT]         = 1'b1;
          rsp_pkt_d[DATA_WIDTH-1:DATA_LSB] = rd_data_q;
          state_d                          = ret_state;
        end
      end
      SLEEP: begin
        if (!i_sink_sleep_req) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rd_data_q   <= '0;
      rsp_wr_en_q <= 1'b0;
      rsp_pkt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rd_data_q   <= rd_data_d;
      rsp_wr_en_q <= rsp_wr_en_d;
      rsp_pkt_q   <= rsp_pkt_d;
      err_q       <= err_d;
    end
  end

  assign PADDR             = paddr_q;
  assign PWDATA            = pwdata_q;
  assign PWRITE            = pwrite_q;
  assign PSEL              = psel_q;
  assign PENABLE           = penable_q;
  assign rsp_fifo_wr_en    = rsp_wr_en_q;
  assign o_rsp_packet      = rsp_pkt_q;
  assign o_err             = err_q;
  assign sink_sleep_status = drain_q;
  assign o_sink_sleep_ack  = (state_q == SLEEP);

endmodule
